// File: rtl/mux_sweep_checker.sv
// Stimulus-and-check engine for 2^SEL_W:1 mux DUTs: drives D/S, waits SETTLE cycles,
// samples Y and streams one truth-table row per combination with a running mismatch count.
module mux_sweep_checker #(
  parameter int SEL_W = 2,
  parameter int CHANNELS = 2 ** SEL_W,
  parameter logic [CHANNELS-1:0] PATTERN = CHANNELS'(4'b1011),
  parameter int EXHAUSTIVE = 0,
  parameter int SETTLE = 2
) (
  input  logic                      CLK,
  input  logic                      nRESET,
  input  logic                      start,
  output logic [CHANNELS-1:0]       D_out,
  output logic [SEL_W-1:0]          S_out,
  input  logic                      Y_in,
  output logic                      row_valid,
  input  logic                      row_ready,
  output logic [SEL_W+CHANNELS-1:0] row_index,
  output logic [SEL_W+CHANNELS-1:0] row_inputs,
  output logic                      row_y,
  output logic                      row_expected,
  output logic                      row_pass,
  output logic                      busy,
  output logic                      done,
  output logic [15:0]               err_count,
  output logic [2:0]                state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_EMIT   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [SEL_W-1:0]    SEL_LAST  = '1;
  localparam logic [CHANNELS-1:0] PAT_LAST  = '1;
  localparam logic [7:0]          SETTLE_LD = 8'(SETTLE);

  state_t                state;
  state_t                state_next;
  logic [SEL_W-1:0]      sel;
  logic [CHANNELS-1:0]   pattern;
  logic [7:0]            settle_cnt;
  logic                  last_row;
  logic                  y_expected;
  logic                  mismatch;

  assign last_row   = (sel == SEL_LAST) && ((EXHAUSTIVE == 0) || (pattern == PAT_LAST));
  assign y_expected = D_out[S_out];
  assign mismatch   = (Y_in != y_expected);
  assign state_dbg  = state;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) state <= S_IDLE;
    else         state <= state_next;
  end

  // Row stream: a row transfers on a rising CLK edge where row_valid && row_ready;
  // row_valid is high for the whole of EMIT and every row_* field is frozen until then.
  always_comb begin
    state_next = state;
    row_valid  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_DRIVE;
      end
      S_DRIVE: begin
        busy       = 1'b1;
        state_next = S_SETTLE;
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (settle_cnt == 8'd1) state_next = S_SAMPLE;
      end
      S_SAMPLE: begin
        busy       = 1'b1;
        state_next = S_EMIT;
      end
      S_EMIT: begin
        busy      = 1'b1;
        row_valid = 1'b1;
        if (row_ready) state_next = last_row ? S_DONE : S_DRIVE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      sel          <= '0;
      pattern      <= '0;
      settle_cnt   <= '0;
      D_out        <= '0;
      S_out        <= '0;
      row_index    <= '0;
      row_inputs   <= '0;
      row_y        <= 1'b0;
      row_expected <= 1'b0;
      row_pass     <= 1'b0;
      err_count    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sel       <= '0;
            pattern   <= (EXHAUSTIVE != 0) ? '0 : PATTERN;
            err_count <= '0;
          end
        end
        S_DRIVE: begin
          S_out      <= sel;
          D_out      <= pattern;
          settle_cnt <= SETTLE_LD;
        end
        S_SETTLE: begin
          settle_cnt <= settle_cnt - 8'd1;
        end
        S_SAMPLE: begin
          row_y        <= Y_in;
          row_expected <= y_expected;
          row_pass     <= !mismatch;
          row_index    <= {pattern, sel};
          row_inputs   <= {S_out, D_out};
          if (mismatch && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
        end
        S_EMIT: begin
          // sel wraps naturally at CHANNELS-1; the pattern steps on that wrap
          if (row_ready && !last_row) begin
            sel <= sel + 1'b1;
            if ((EXHAUSTIVE != 0) && (sel == SEL_LAST)) pattern <= pattern + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sweep_checker.sv
// Bench for mux_sweep_checker: a 4:1 select sweep instance and a 2:1 exhaustive instance,
// each beside a behavioural mux whose output can be stuck at 0 or flipped per row.
module tb_mux_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cur = 0;
  int   fault_mode = 0;
  bit   flip_tbl [0:63];

  // instance a: SEL_W=2, select sweep over PATTERN 4'b1011, SETTLE=2
  logic       a_start = 1'b0, a_ready = 1'b0, a_y;
  logic [3:0] a_d;
  logic [1:0] a_s;
  logic       a_valid, a_yo, a_exp, a_pass, a_busy, a_done;
  logic [5:0] a_index, a_inputs;
  logic [15:0] a_err;
  logic [2:0] a_state;

  // instance b: SEL_W=1, exhaustive sweep, SETTLE=1
  logic       b_start = 1'b0, b_ready = 1'b0, b_y;
  logic [1:0] b_d;
  logic [0:0] b_s;
  logic       b_valid, b_yo, b_exp, b_pass, b_busy, b_done;
  logic [2:0] b_index, b_inputs;
  logic [15:0] b_err;
  logic [2:0] b_state;

  assign a_y = (fault_mode == 1) ? 1'b0 : (a_d[a_s] ^ ((fault_mode == 2) && flip_tbl[{a_d, a_s}]));
  assign b_y = (fault_mode == 1) ? 1'b0 : (b_d[b_s] ^ ((fault_mode == 2) && flip_tbl[{b_d, b_s}]));

  mux_sweep_checker #(.SEL_W(2), .EXHAUSTIVE(0), .SETTLE(2)) dut_a (
    .CLK(clk), .nRESET(rst_n), .start(a_start), .D_out(a_d), .S_out(a_s), .Y_in(a_y),
    .row_valid(a_valid), .row_ready(a_ready), .row_index(a_index), .row_inputs(a_inputs),
    .row_y(a_yo), .row_expected(a_exp), .row_pass(a_pass), .busy(a_busy), .done(a_done),
    .err_count(a_err), .state_dbg(a_state)
  );

  mux_sweep_checker #(.SEL_W(1), .EXHAUSTIVE(1), .SETTLE(1)) dut_b (
    .CLK(clk), .nRESET(rst_n), .start(b_start), .D_out(b_d), .S_out(b_s), .Y_in(b_y),
    .row_valid(b_valid), .row_ready(b_ready), .row_index(b_index), .row_inputs(b_inputs),
    .row_y(b_yo), .row_expected(b_exp), .row_pass(b_pass), .busy(b_busy), .done(b_done),
    .err_count(b_err), .state_dbg(b_state)
  );

  // view of whichever instance is under test
  logic        v_valid, v_y, v_exp, v_pass, v_busy, v_done;
  logic [31:0] v_index, v_inputs, v_d, v_s;
  logic [15:0] v_err;
  always_comb begin
    if (cur == 0) begin
      v_valid = a_valid; v_y = a_yo; v_exp = a_exp; v_pass = a_pass; v_busy = a_busy;
      v_done = a_done; v_index = 32'(a_index); v_inputs = 32'(a_inputs);
      v_d = 32'(a_d); v_s = 32'(a_s); v_err = a_err;
    end else begin
      v_valid = b_valid; v_y = b_yo; v_exp = b_exp; v_pass = b_pass; v_busy = b_busy;
      v_done = b_done; v_index = 32'(b_index); v_inputs = 32'(b_inputs);
      v_d = 32'(b_d); v_s = 32'(b_s); v_err = b_err;
    end
  end

  // scoreboard entry: {index[15:0], inputs[15:0], y, expected, pass, err_after_row[15:0]}
  logic [50:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_start(input logic v);
    if (cur == 0) a_start = v; else b_start = v;
  endtask

  task automatic set_ready(input logic v);
    if (cur == 0) a_ready = v; else b_ready = v;
  endtask

  // Reference: enumerate the truth table in row order and push the rows it must emit.
  task automatic build_model(input int which, input int mode, output int rows, output int errs);
    int ch, npat, p, idx, inp;
    bit e, y;
    ch   = (which == 0) ? 4 : 2;
    npat = (which == 0) ? 1 : (1 << ch);
    exp_q.delete();
    rows = 0;
    errs = 0;
    for (int pi = 0; pi < npat; pi++) begin
      p = (which == 0) ? 11 : pi;
      for (int s = 0; s < ch; s++) begin
        idx = p * ch + s;
        inp = s * (1 << ch) + p;
        e   = bit'((p >> s) & 1);
        y   = (mode == 1) ? 1'b0 : (e ^ ((mode == 2) && flip_tbl[idx]));
        if (y != e) errs++;
        exp_q.push_back({16'(idx), 16'(inp), y, e, (y == e), 16'(errs)});
        rows++;
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_d"}, 32'(a_d), 0);
    check({tag, "_s"}, 32'(a_s), 0);
    check({tag, "_valid"}, 32'(a_valid), 0);
    check({tag, "_index"}, 32'(a_index), 0);
    check({tag, "_inputs"}, 32'(a_inputs), 0);
    check({tag, "_y"}, 32'(a_yo), 0);
    check({tag, "_exp"}, 32'(a_exp), 0);
    check({tag, "_pass"}, 32'(a_pass), 0);
    check({tag, "_busy"}, 32'(a_busy), 0);
    check({tag, "_done"}, 32'(a_done), 0);
    check({tag, "_err"}, 32'(a_err), 0);
    check({tag, "_b_busy"}, 32'(b_busy), 0);
  endtask

  // One full sweep; cycle 1 is the cycle start is held high, done is expected in
  // cycle 2 + rows*(SETTLE+3) + stalled EMIT cycles.
  task automatic run_sweep(input int which, input int mode, input int stall_pct,
                           input int stall_row, input int stall_len, input bit start_in_emit,
                           output int done_cyc, output int err_seen);
    int rows, errs, stalls, row, held, settle, ch, cyc, last_pat;
    bit rdy, seen_done;
    logic [50:0] e;
    cur = which;
    fault_mode = mode;
    build_model(which, mode, rows, errs);
    settle   = (which == 0) ? 2 : 1;
    ch       = (which == 0) ? 4 : 2;
    last_pat = (which == 0) ? 11 : 3;
    done_cyc = -1;
    err_seen = -1;
    @(negedge clk);
    set_start(1'b1);
    set_ready(1'b1);
    cyc = 1; stalls = 0; row = 0; held = 0; seen_done = 1'b0;
    while (!seen_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      set_start(1'b0);
      if (cyc == 2) check("busy_in_drive", 32'(v_busy), 1);
      if (cyc == 3) begin
        check("drive_s", v_s, 0);
        check("drive_d", v_d, (which == 0) ? 11 : 0);
      end
      if (v_done) begin
        seen_done = 1'b1;
        done_cyc  = cyc;
        err_seen  = int'(v_err);
        check("done_cycle", 32'(cyc), 32'(2 + rows * (settle + 3) + stalls));
        check("done_err", 32'(v_err), 32'(errs));
        check("done_busy", 32'(v_busy), 0);
        check("rows_left", 32'(exp_q.size()), 0);
        check("hold_s", v_s, 32'(ch - 1));
        check("hold_d", v_d, 32'(last_pat));
      end else if (v_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_row", 32'(v_index), 32'hFFFF_FFFF);
          set_ready(1'b1);
        end else begin
          e = exp_q[0];
          check("row_index", v_index, 32'(e[50:35]));
          check("row_inputs", v_inputs, 32'(e[34:19]));
          check("row_y", 32'(v_y), 32'(e[18]));
          check("row_expected", 32'(v_exp), 32'(e[17]));
          check("row_pass", 32'(v_pass), 32'(e[16]));
          check("row_err", 32'(v_err), 32'(e[15:0]));
          check("emit_s", v_s, 32'(e[50:35]) % 32'(ch));
          if (start_in_emit && row == 0) set_start(1'b1);
          rdy = 1'b1;
          if (row == stall_row && held < stall_len) begin
            rdy = 1'b0;
            held++;
          end else if ($urandom_range(0, 99) < stall_pct) begin
            rdy = 1'b0;
          end
          if (!rdy) stalls++;
          else begin
            void'(exp_q.pop_front());
            row++;
            held = 0;
          end
          set_ready(rdy);
        end
      end else begin
        set_ready(1'($urandom_range(0, 1)));
      end
    end
    if (!seen_done) check("done_timeout", 32'(cyc), 0);
    set_ready(1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("done_single", 32'(v_done), 0);
      check("idle_after", 32'(v_busy), 0);
    end
  endtask

  typedef struct {
    string name;
    int    which;
    int    mode;
    int    stall_row;
    int    stall_len;
    bit    start_emit;
    int    exp_err;
    int    exp_done;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int dc, es;
    vecs[0] = '{"good4",      0, 0, -1, 0, 1'b0, 0, 22};
    vecs[1] = '{"stuck4",     0, 1, -1, 0, 1'b0, 3, 22};
    vecs[2] = '{"backpress",  0, 0,  1, 7, 1'b0, 0, 29};
    vecs[3] = '{"exh2",       1, 0, -1, 0, 1'b0, 0, 34};
    vecs[4] = '{"exh2_stuck", 1, 1, -1, 0, 1'b0, 4, 34};
    vecs[5] = '{"start_emit", 0, 0, -1, 0, 1'b1, 0, 22};
    for (int i = 0; i < 64; i++) flip_tbl[i] = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_sweep(vecs[i].which, vecs[i].mode, 0, vecs[i].stall_row, vecs[i].stall_len,
                vecs[i].start_emit, dc, es);
      check({vecs[i].name, "_done_at"}, 32'(dc), 32'(vecs[i].exp_done));
      check({vecs[i].name, "_err"}, 32'(es), 32'(vecs[i].exp_err));
    end

    // asynchronous reset during SETTLE of row 2 (cycles 12..16 hold row 2, 13 is SETTLE)
    cur = 0;
    fault_mode = 1;
    @(negedge clk);
    a_start = 1'b1;
    a_ready = 1'b1;
    repeat (12) begin
      @(negedge clk);
      a_start = 1'b0;
    end
    check("pre_rst_s", 32'(a_s), 2);
    check("pre_rst_busy", 32'(a_busy), 1);
    check("pre_rst_err", 32'(a_err), 2);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    fault_mode = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_sweep(0, 0, 0, -1, 0, 1'b0, dc, es);
    check("after_rst_done", 32'(dc), 22);

    // randomized back-pressure and per-row output flips
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 64; i++) flip_tbl[i] = ($urandom_range(0, 3) == 0);
      run_sweep(int'($urandom_range(0, 1)), 2, int'($urandom_range(0, 50)), -1, 0, 1'b0, dc, es);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
